ir_cmd_decoder: RTL and testbench

//  Sits between IR_RECEIVE and DualMotorControlFinal / the uart_tx byte builder.

---
 rtl/ir_cmd_decoder.sv | 140 ++++++++++++++
 tb/tb_ir_cmd_decoder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ir_cmd_decoder.sv
// NEC frame validator and drive-command holder with repeat-extended timeout.
// Define IR_ADDR_FILTER_EN to reject frames whose address differs from DEV_ADDR.
module ir_cmd_decoder #(
  parameter int          CLK_HZ   = 50_000_000,
  parameter int          HOLD_MS  = 120,
  parameter logic [7:0]  DEV_ADDR = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ir_ready,
  input  logic [31:0] ir_data,
  output logic [7:0]  cmd_onehot,
  output logic [2:0]  cmd_code,
  output logic        cmd_active,
  output logic        cmd_new,
  output logic        timeout,
  output logic [7:0]  err_count
);
  localparam int HOLD_CYCLES = (CLK_HZ / 1000) * HOLD_MS;
  localparam int TW = $clog2(HOLD_CYCLES + 1);
  localparam logic [TW-1:0] RELOAD = TW'(HOLD_CYCLES - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t      state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic        rdy_q;
  logic        frm_q;
  logic [31:0] data_q;

  logic [7:0]  oh_d;
  logic [2:0]  code_d;
  logic        act_d, new_d, to_d;
  logic [7:0]  err_d;

  logic        cmpl_ok, valid, mapped, accept;
  logic        do_map, do_stop, do_exp, do_tick;
  logic [7:0]  map_oh;
  logic [2:0]  map_code;

  assign cmpl_ok = (data_q[31:24] == ~data_q[23:16]) &&
                   (data_q[15:8]  == ~data_q[7:0]);

`ifdef IR_ADDR_FILTER_EN
  assign valid = cmpl_ok && (data_q[7:0] == DEV_ADDR);
`else
  assign valid = cmpl_ok;
  logic unused_dev_addr;
  assign unused_dev_addr = ^DEV_ADDR;
`endif

  always_comb begin
    map_oh   = 8'h00;
    map_code = 3'd0;
    mapped   = 1'b1;
    case (data_q[23:16])
      8'h02: begin map_oh = 8'h02; map_code = 3'd1; end
      8'h04: begin map_oh = 8'h08; map_code = 3'd3; end
      8'h05: begin map_oh = 8'h10; map_code = 3'd4; end
      8'h06: begin map_oh = 8'h20; map_code = 3'd5; end
      8'h08: begin map_oh = 8'h80; map_code = 3'd7; end
      default: mapped = 1'b0;
    endcase
  end

  // An accepted frame always wins over a coincident expiry.
  assign accept  = frm_q && valid;
  assign do_map  = accept && mapped;
  assign do_stop = accept && !mapped;
  assign do_exp  = !accept && (state_q == ACTIVE) && (timer_q == '0);
  assign do_tick = !accept && (state_q == ACTIVE) && (timer_q != '0);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    oh_d    = cmd_onehot;
    code_d  = cmd_code;
    act_d   = cmd_active;
    new_d   = 1'b0;
    to_d    = 1'b0;
    err_d   = err_count;
    if (frm_q && !valid && err_count != 8'hFF)
      err_d = err_count + 8'd1;
    unique case (1'b1)
      do_map: begin
        state_d = ACTIVE;
        timer_d = RELOAD;
        oh_d    = map_oh;
        code_d  = map_code;
        act_d   = 1'b1;
        new_d   = (map_oh != cmd_onehot);
      end
      do_stop: begin
        state_d = IDLE;
        timer_d = '0;
        oh_d    = 8'h00;
        code_d  = 3'd0;
        act_d   = 1'b0;
      end
      do_exp: begin
        state_d = IDLE;
        oh_d    = 8'h00;
        code_d  = 3'd0;
        act_d   = 1'b0;
        to_d    = 1'b1;
      end
      do_tick: timer_d = timer_q - TW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdy_q      <= 1'b1;
      frm_q      <= 1'b0;
      data_q     <= '0;
      state_q    <= IDLE;
      timer_q    <= '0;
      cmd_onehot <= 8'h00;
      cmd_code   <= 3'd0;
      cmd_active <= 1'b0;
      cmd_new    <= 1'b0;
      timeout    <= 1'b0;
      err_count  <= 8'h00;
    end else begin
      rdy_q      <= ir_ready;
      frm_q      <= ir_ready && !rdy_q;
      if (ir_ready && !rdy_q)
        data_q   <= ir_data;
      state_q    <= state_d;
      timer_q    <= timer_d;
      cmd_onehot <= oh_d;
      cmd_code   <= code_d;
      cmd_active <= act_d;
      cmd_new    <= new_d;
      timeout    <= to_d;
      err_count  <= err_d;
    end
  end
endmodule

// File: tb/tb_ir_cmd_decoder.sv
// Bench for ir_cmd_decoder: deadline-based model checked every cycle,
// plus directed literal checks (HOLD_CYCLES = 100).
module tb_ir_cmd_decoder;
  localparam int HOLD = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ir_ready = 1'b0;
  logic [31:0] ir_data = '0;
  logic [7:0]  cmd_onehot;
  logic [2:0]  cmd_code;
  logic        cmd_active, cmd_new, timeout;
  logic [7:0]  err_count;

  int n_vec = 0;
  int n_bad = 0;

  ir_cmd_decoder #(
    .CLK_HZ(10_000), .HOLD_MS(10), .DEV_ADDR(8'h00)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ir_ready(ir_ready), .ir_data(ir_data),
    .cmd_onehot(cmd_onehot), .cmd_code(cmd_code), .cmd_active(cmd_active),
    .cmd_new(cmd_new), .timeout(timeout), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Model: edge-indexed events; hold expires at a fixed deadline edge.
  int          ecyc = 0;
  bit          m_prev = 1'b1;
  bit          pend = 1'b0;
  int          pend_at = 0;
  logic [31:0] pend_data = '0;
  logic [7:0]  m_oh = 0;
  logic [2:0]  m_code = 0;
  bit          m_act = 0, m_new = 0, m_to = 0;
  int          m_err = 0;
  int          deadline = 0;

  function automatic logic [7:0] cmd_to_oh(input logic [7:0] c);
    case (c)
      8'h02: return 8'h02;
      8'h04: return 8'h08;
      8'h05: return 8'h10;
      8'h06: return 8'h20;
      8'h08: return 8'h80;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_step(input bit r, input bit rd, input logic [31:0] d);
    bit took;
    logic [7:0] oh;
    bit ok;
    ecyc++;
    m_new = 0;
    m_to = 0;
    took = 0;
    if (!r) begin
      m_oh = 0; m_code = 0; m_act = 0; m_err = 0;
      m_prev = 1; pend = 0;
      return;
    end
    if (pend && pend_at == ecyc) begin
      pend = 0;
      ok = (pend_data[31:24] == ~pend_data[23:16]) &&
           (pend_data[15:8] == ~pend_data[7:0]);
`ifdef IR_ADDR_FILTER_EN
      ok = ok && (pend_data[7:0] == 8'h00);
`endif
      if (!ok) begin
        if (m_err < 255) m_err++;
      end else begin
        took = 1;
        oh = cmd_to_oh(pend_data[23:16]);
        if (oh != 0) begin
          m_new = (oh != m_oh);
          m_oh = oh;
          m_act = 1;
          deadline = ecyc + HOLD;
        end else begin
          m_oh = 0;
          m_act = 0;
        end
      end
    end
    if (!took && m_act && ecyc == deadline) begin
      m_oh = 0; m_act = 0; m_to = 1;
    end
    m_code = 0;
    for (int i = 0; i < 8; i++)
      if (m_oh[i]) m_code = 3'(i);
    if (rd && !m_prev) begin
      pend = 1; pend_at = ecyc + 1; pend_data = d;
    end
    m_prev = rd;
  endtask

  always @(posedge clk) begin
    model_step(rst_n, ir_ready, ir_data);
    #1;
    n_vec++;
    if (cmd_onehot !== m_oh || cmd_code !== m_code ||
        cmd_active !== m_act || cmd_new !== m_new ||
        timeout !== m_to || err_count !== 8'(m_err)) begin
      n_bad++;
      $display("FAIL cycle%0d: got oh=%h code=%0d act=%b new=%b to=%b err=%0d want oh=%h code=%0d act=%b new=%b to=%b err=%0d",
               ecyc, cmd_onehot, cmd_code, cmd_active, cmd_new, timeout,
               err_count, m_oh, m_code, m_act, m_new, m_to, m_err);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic frame(input logic [31:0] d, input bit hold = 1'b0);
    @(negedge clk);
    ir_data = d;
    ir_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    if (!hold) ir_ready = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_oh", cmd_onehot, 8'h00);
    chk("reset_err", err_count, 0);
    rst_n = 1'b1;

    frame(32'hFD02_FF00);
    chk("t1_oh", cmd_onehot, 8'h02);
    chk("t1_code", cmd_code, 1);
    chk("t1_new", cmd_new, 1);
    @(negedge clk);
    chk("t1_new_once", cmd_new, 0);
    repeat (98) @(negedge clk);
    chk("t1_still_act", cmd_active, 1);
    @(negedge clk);
    chk("t1_timeout", timeout, 1);
    chk("t1_oh_clr", cmd_onehot, 8'h00);
    @(negedge clk);
    chk("t1_to_pulse", timeout, 0);

    frame(32'hFC02_FF00);
    chk("t2_err1", err_count, 1);
    chk("t2_oh", cmd_onehot, 8'h00);
    repeat (255) frame(32'hFC02_FF00);
    chk("t2_sat", err_count, 8'hFF);

    frame(32'hFD02_FF00);
    repeat (78) @(negedge clk);
    frame(32'hFD02_FF00);
    chk("t3_repeat_nonew", cmd_new, 0);
    repeat (40) @(negedge clk);
    chk("t3_extended", cmd_active, 1);
    frame(32'hF906_FF00);
    chk("t3_oh", cmd_onehot, 8'h20);
    chk("t3_code", cmd_code, 5);
    chk("t3_new", cmd_new, 1);

    repeat (97) @(negedge clk);
    frame(32'hF906_FF00);
    chk("t4_no_to", timeout, 0);
    chk("t4_act", cmd_active, 1);
    frame(32'hEE11_FF00);
    chk("t4_stop_oh", cmd_onehot, 8'h00);
    chk("t4_stop_to", timeout, 0);
    repeat (5) @(negedge clk);

    frame(32'hFD02_FF00, 1'b1);
    chk("t5_pre", cmd_active, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t5_rst_oh", cmd_onehot, 8'h00);
    chk("t5_rst_err", err_count, 0);
    repeat (5) @(negedge clk);
    chk("t5_no_frame", cmd_active, 0);
    ir_ready = 1'b0;
    @(negedge clk);

    frame(32'hFD02_FE01);
`ifdef IR_ADDR_FILTER_EN
    chk("t6_reject", err_count, 1);
    chk("t6_reject_oh", cmd_onehot, 8'h00);
`else
    chk("t6_accept", err_count, 0);
    chk("t6_accept_oh", cmd_onehot, 8'h02);
`endif
    frame(32'hFD02_FF00);
    chk("t6_oh", cmd_onehot, 8'h02);
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
